// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and types for the two-master WISHBONE arbiter
package wb_pkg;

  // Default widths and slave-select bit of the shared bus
  localparam int WB_AW        = 26;
  localparam int WB_DW        = 32;
  localparam int WB_SEL_BIT   = 16;
  localparam int WB_TO_CYCLES = 16;

  // Slave tag values carried on s_taga_o
  localparam logic TAG_MEM = 1'b0;
  localparam logic TAG_SSP = 1'b1;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_t;

  // Index of the owner encoded in a one-hot grant (0 = m0, 1 = m1)
  function automatic logic gnt_to_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational two-way round-robin winner picker
module wb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // Sole requester wins; on a tie the master that did not own the bus last wins
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master cyc-locked round-robin WISHBONE arbiter with stall timeout
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int AW        = WB_AW,
  parameter int DW        = WB_DW,
  parameter int SEL_BIT   = WB_SEL_BIT,
  parameter int TO_CYCLES = WB_TO_CYCLES
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_taga_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  localparam int            CW      = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [1:0]    r_gnt, w_gnt_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [1:0]    w_req;
  logic [1:0]    w_win;
  logic          w_bus_on;
  logic          w_in_err;
  logic          w_own_cyc;
  logic          w_own_stb;
  logic          w_own_we;
  logic [AW-1:0] w_own_adr;
  logic [DW-1:0] w_own_dat;

  assign w_req = {m1_cyc_i, m0_cyc_i};

  wb_rr_pick u_pick (
    .req  (w_req),
    .last (r_last),
    .win  (w_win)
  );

  // Select the current owner's request signals
  always_comb begin
    if (r_gnt[1]) begin
      w_own_cyc = m1_cyc_i;
      w_own_stb = m1_stb_i;
      w_own_we  = m1_we_i;
      w_own_adr = m1_adr_i;
      w_own_dat = m1_dat_i;
    end else begin
      w_own_cyc = m0_cyc_i;
      w_own_stb = m0_stb_i;
      w_own_we  = m0_we_i;
      w_own_adr = m0_adr_i;
      w_own_dat = m0_dat_i;
    end
  end

  // Bus is driven only while a master owns it; IDLE and ERR present an idle bus
  assign w_bus_on = (r_state == ST_OWN);
  assign w_in_err = (r_state == ST_ERR);

  assign s_cyc_o  = w_bus_on & w_own_cyc;
  assign s_stb_o  = w_bus_on & w_own_stb;
  assign s_we_o   = w_bus_on & w_own_we;
  assign s_adr_o  = w_bus_on ? w_own_adr : '0;
  assign s_dat_o  = w_bus_on ? w_own_dat : '0;
  assign s_taga_o = s_adr_o[SEL_BIT];

  assign dat_o    = s_dat_i;
  assign gnt_o    = r_gnt;

  // Acks reach only the owner and only while it owns the bus
  assign m0_ack_o = s_ack_i & w_bus_on & r_gnt[0];
  assign m1_ack_o = s_ack_i & w_bus_on & r_gnt[1];
  assign m0_err_o = w_in_err & r_gnt[0];
  assign m1_err_o = w_in_err & r_gnt[1];

  // Next-state: arbitration, cyc-locked hold, release and stall timeout
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = 2'b00;
        w_cnt_nxt = '0;
        if (|w_req) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = w_win;
        end
      end
      ST_OWN: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
          w_last_nxt  = gnt_to_idx(r_gnt);
          w_cnt_nxt   = '0;
        end else if (s_ack_i) begin
          w_cnt_nxt = '0;
        end else if (w_own_stb) begin
          // The TO_CYCLES-th stalled cycle moves to ERR at its closing edge
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == TO_LAST) begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
        w_last_nxt  = gnt_to_idx(r_gnt);
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, grant, round-robin history and timeout counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

  localparam int AW        = 26;
  localparam int DW        = 32;
  localparam int SEL_BIT   = 16;
  localparam int TO_CYCLES = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [AW-1:0] m0_adr_i = '0;
  logic [DW-1:0] m0_dat_i = '0;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [DW-1:0] m1_dat_i = '0;
  logic          m1_ack_o, m1_err_o;
  logic [DW-1:0] dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_taga_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 1'b0;
  logic [1:0]    gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  wb_bus_arbiter #(
    .AW(AW), .DW(DW), .SEL_BIT(SEL_BIT), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .dat_o(dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_taga_o(s_taga_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1'b1;
    #3;
    chk("rst_gnt",   64'(gnt_o), 64'h0);
    chk("rst_s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_taga_o}), 64'h0);
    chk("rst_s_adr", 64'(s_adr_o), 64'h0);
    chk("rst_m_out", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'h0);
    chk("rst_dat_o", 64'(dat_o), 64'hDEAD_BEEF);
    s_ack_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;

    // Tie out of reset: m0 wins, m1 follows after one idle cycle, m0 wins the next tie
    m0_cyc_i = 1'b1;
    m1_cyc_i = 1'b1;
    #1;
    chk("tie_latency_gnt", 64'(gnt_o), 64'h0);
    tick();
    chk("tie_first_gnt", 64'(gnt_o), 64'h1);
    chk("tie_s_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h2);
    tick();
    chk("tie_hold_gnt", 64'(gnt_o), 64'h1);
    m0_cyc_i = 1'b0;
    #1;
    chk("tie_release_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    chk("tie_idle_gap", 64'(gnt_o), 64'h0);
    tick();
    chk("tie_m1_gnt", 64'(gnt_o), 64'h2);
    m0_cyc_i = 1'b1;
    tick();
    chk("tie_m1_hold", 64'(gnt_o), 64'h2);
    m1_cyc_i = 1'b0;
    tick();
    chk("tie_idle_gap2", 64'(gnt_o), 64'h0);
    m1_cyc_i = 1'b1;
    tick();
    chk("tie_m0_again", 64'(gnt_o), 64'h1);
    m0_cyc_i = 1'b0;
    m1_cyc_i = 1'b0;
    tick();
    chk("tie_end_idle", 64'(gnt_o), 64'h0);

    // Single read by m0 from memory, slave acks two cycles after stb
    m0_cyc_i = 1'b1;
    m0_stb_i = 1'b1;
    m0_we_i  = 1'b0;
    m0_adr_i = 26'h0_0010;
    s_dat_i  = 32'h1234_5678;
    #1;
    chk("rd_latency_gnt", 64'(gnt_o), 64'h0);
    tick();
    chk("rd_gnt", 64'(gnt_o), 64'h1);
    chk("rd_s_adr", 64'(s_adr_o), 64'h10);
    chk("rd_taga", 64'(s_taga_o), 64'h0);
    chk("rd_stb", 64'(s_stb_o), 64'h1);
    chk("rd_ack_w0", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    tick();
    chk("rd_ack_w1", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_0001;
    #1;
    chk("rd_ack", 64'({m0_ack_o, m1_ack_o}), 64'h2);
    chk("rd_dat_o", 64'(dat_o), 64'hCAFE_0001);
    tick();
    s_ack_i  = 1'b0;
    m0_cyc_i = 1'b0;
    m0_stb_i = 1'b0;
    #1;
    chk("rd_ack_after", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    tick();
    chk("rd_idle", 64'(gnt_o), 64'h0);

    // Locked burst: m1 writes 4 beats to SSP while m0 requests throughout
    m1_cyc_i = 1'b1;
    m1_stb_i = 1'b1;
    m1_we_i  = 1'b1;
    m1_adr_i = 26'h1_0004;
    m1_dat_i = 32'h0000_00A0;
    m0_cyc_i = 1'b1;
    m0_stb_i = 1'b1;
    m0_adr_i = 26'h0_0020;
    s_ack_i  = 1'b1;
    #1;
    chk("idle_ack_ignored", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("burst_gnt",   64'(gnt_o), 64'h2);
      chk("burst_taga",  64'(s_taga_o), 64'h1);
      chk("burst_we",    64'(s_we_o), 64'h1);
      chk("burst_dat",   64'(s_dat_o), 64'(32'hA0 + b));
      chk("burst_acks",  64'({m0_ack_o, m1_ack_o}), 64'h1);
      m1_dat_i = 32'hA0 + 32'(b) + 32'd1;
      if (b == 3) s_ack_i = 1'b0;
      tick();
    end
    chk("burst_still_m1", 64'(gnt_o), 64'h2);
    chk("burst_no_ack", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    m1_cyc_i = 1'b0;
    m1_stb_i = 1'b0;
    m1_we_i  = 1'b0;
    tick();
    chk("burst_idle", 64'(gnt_o), 64'h0);
    tick();
    chk("burst_m0_gnt", 64'(gnt_o), 64'h1);

    // Timeout: m0 strobes, slave never acks
    for (int k = 0; k < TO_CYCLES; k++) begin
      chk("to_wait", 64'({s_cyc_o, m0_err_o}), 64'h2);
      tick();
    end
    chk("to_err", 64'({m0_err_o, m1_err_o}), 64'h2);
    chk("to_cyc_drop", 64'({s_cyc_o, s_stb_o}), 64'h0);
    s_ack_i = 1'b1;
    #1;
    chk("err_ack_ignored", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    m0_cyc_i = 1'b0;
    m0_stb_i = 1'b0;
    tick();
    chk("to_err_once", 64'({m0_err_o, m1_err_o}), 64'h0);
    chk("to_idle", 64'(gnt_o), 64'h0);
    chk("late_ack", 64'({m0_ack_o, m1_ack_o}), 64'h0);
    s_ack_i = 1'b0;

    // Reset mid-transfer while m1 owns the bus
    m1_cyc_i = 1'b1;
    m1_stb_i = 1'b1;
    m1_adr_i = 26'h1_0008;
    tick();
    chk("mr_own", 64'({gnt_o, s_cyc_o, s_stb_o}), 64'hB);
    #3;
    rst_i = 1'b0;
    #1;
    chk("mr_async_drop", 64'({gnt_o, s_cyc_o, s_stb_o}), 64'h0);
    m1_stb_i = 1'b0;
    m0_cyc_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk("mr_tie_m0", 64'(gnt_o), 64'h1);
    m0_cyc_i = 1'b0;
    m1_cyc_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master WISHBONE arbiter sharing the single slave bus (program memory and SSP) between the ARM-side WISHBONE master and a second master (DMA engine). Grants the bus round-robin, holds the grant for a whole cycle (cyc-locked), and muxes address, data and control onto the shared bus. Routes `ack` back to the owner only, and aborts stalled slave accesses with a bus-error pulse after a fixed timeout.

## Interface
- `AW`, 26, address width
- `DW`, 32, data width
- `SEL_BIT`, 16, address bit selecting slave: 0 = memory, 1 = SSP (drives `taga_o`)
- `TO_CYCLES`, 16, max cycles a strobe may wait for `ack_i` (≥2)

- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (ARM) control
- `m0_adr_i`  in  AW  master 0 address
- `m0_dat_i`  in  DW  master 0 write data
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 acknowledge / bus error
- `m1_*`  same set as `m0_*`  master 1 (DMA)
- `dat_o`  out  DW  read data broadcast to both masters (= `s_dat_i`)
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  shared bus control
- `s_adr_o`  out  AW  shared bus address
- `s_dat_o`  out  DW  shared bus write data
- `s_taga_o`  out  1  `s_adr_o[SEL_BIT]`
- `s_dat_i`  in  DW  slave read data
- `s_ack_i`  in  1  slave acknowledge
- `gnt_o`  out  2  one-hot current owner (status)

## Operation
- States: IDLE, OWN, ERR.
- IDLE: no owner; all `s_*` outputs 0. If any `mX_cyc_i` is high, pick winner and go to OWN with `gnt` = winner.
- Winner: sole requester; both requesting → master ≠ `last`. `last` resets to 1, so m0 wins the first tie.
- OWN: `s_cyc_o`/`s_stb_o`/`s_we_o`/`s_adr_o`/`s_dat_o` = owner's inputs (combinational mux). `mX_ack_o` = `s_ack_i & gnt[X]`; the non-owner sees ack=0, err=0.
- Release: owner drops `cyc` → IDLE next edge, `last` ← owner. A request pending from the other master is arbitrated in that IDLE cycle.
- Timeout: counter clears on entering OWN and on each `s_ack_i`. It increments each cycle in OWN with `s_stb_o`=1 and `s_ack_i`=0. On reaching `TO_CYCLES`, go to ERR.
- ERR, one cycle: `s_cyc_o`/`s_stb_o` forced 0, owner's `err_o`=1. Then → IDLE, `last` ← owner, counter cleared.
- Owner holding `cyc` with `stb`=0: grant kept, counter frozen.
- `s_ack_i` in IDLE or ERR is ignored; no master sees it.
- `s_taga_o` = `s_adr_o[SEL_BIT]`, so it is 0 whenever the bus is idle.

## Timing
- Reset values: state IDLE, `gnt_o`=00, `last`=1, counter 0. All `s_*` outputs, `mX_ack_o` and `mX_err_o` are 0. `dat_o` follows `s_dat_i`.
- Asserting reset mid-transfer drops `s_cyc_o`/`s_stb_o` immediately, with no wait for the clock edge.
- Grant latency: `cyc` seen high at edge N-1→N in IDLE; state becomes OWN at edge N; bus driven from cycle N. One idle cycle always separates two owners.
- `ack` path is combinational, so there is zero added latency per beat. Back-to-back beats within one cyc run at one per cycle.
- Error timing: `err_o` pulses in the cycle after the `TO_CYCLES`-th stalled cycle.

## Structure
- Shared package `wb_pkg`: state encoding (IDLE/OWN/ERR), `AW`/`DW` defaults, `SEL_BIT`, and the slave-select constants `TAG_MEM`=0 and `TAG_SSP`=1.
- One sub-module, `wb_rr_pick`: a combinational 2-way round-robin picker with inputs req[1:0] and last, and a one-hot winner output.
- Timeout counter, FSM and output mux stay in `wb_bus_arbiter`.

## Test plan
- Single master, single read: m0 reads `adr`=0x00010 and the slave acks 2 cycles after stb. Required: grant visible on the cycle after cyc, `s_taga_o`=0, `m0_ack_o` pulses once, `dat_o`=slave data, `m1_ack_o` stays 0.
- Simultaneous request straight out of reset: m0 wins. When m0 releases, m1 is granted after exactly one IDLE cycle. When both request again, m0 wins again (round-robin alternation).
- Locked burst: m1 does 4 back-to-back writes to SSP (`adr`=0x10004), acked each cycle, while m0 requests throughout. Required: m0 is never granted until m1 drops cyc, and `s_taga_o`=1 for all 4 beats.
- Timeout with `TO_CYCLES`=16: the slave never acks. Required: `m0_err_o` pulses exactly once after 16 stalled cycles, `s_cyc_o` drops that cycle, and the arbiter returns to IDLE. A late `s_ack_i` in IDLE produces no master ack.
- Reset mid-transfer: assert `rst_i` low between clock edges while m1 owns the bus. Required: `s_cyc_o`/`s_stb_o`/`gnt_o` go to 0 before the next edge, and the first tie after reset goes to m0.
